// File: rtl/instr_nibble_fifo.sv
// instr_nibble_fifo
//
// Assembles quad-SPI nibbles (MSB-first) into instruction words and queues
// them in a small first-word-fall-through FIFO for the instruction decoder.
// It also throttles the flash reader so that a word already in flight
// always has a free slot.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   nib_in       nibble from quad-SPI, bit 3 = IO3
//   nib_valid    nib_in is valid this cycle
//   flush        synchronous clear of assembler and FIFO contents
//   instr_out    head-of-FIFO instruction (qualify with instr_valid)
//   instr_valid  FIFO holds at least one word
//   instr_ready  decoder accepts the head word this cycle
//   fetch_enable high while there is room for another instruction
//   count        occupied entries, 0..DEPTH
//   overflow     sticky: a completed word was dropped because the FIFO was full
//   starve       sticky: decoder asked for a word while empty, after the first word
//
// NIBBLES must be at least 3 so the assembler shift register can be sliced.
module instr_nibble_fifo #(
  parameter int NIBBLES = 5,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             nib_in,
  input  logic                   nib_valid,
  input  logic                   flush,
  output logic [4*NIBBLES-1:0]   instr_out,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   fetch_enable,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  output logic                   starve
);

  localparam int WORD_W = 4 * NIBBLES;
  localparam int SH_W   = 4 * (NIBBLES - 1);
  localparam int CNT_W  = $clog2(NIBBLES);

  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  HIGH_CNT = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]  ONE_CNT  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR = ADDR_W'(1);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] ONE_NIB  = CNT_W'(1);

  // Assembler state
  logic [SH_W-1:0]   shift_r;
  logic [CNT_W-1:0]  nib_cnt_r;

  // FIFO storage and bookkeeping
  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              valid_r;
  logic              fetch_r;

  // Sticky status
  logic              overflow_r;
  logic              starve_r;
  logic              primed_r;

  // Per-cycle decisions
  logic              last_nib_s;
  logic [WORD_W-1:0] word_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              do_pop_s;
  logic [ADDR_W:0]   count_next_s;

  // Decide push/pop/drop for this edge and the resulting occupancy.
  always_comb begin
    last_nib_s   = 1'b0;
    word_s       = '0;
    pop_s        = 1'b0;
    push_s       = 1'b0;
    drop_s       = 1'b0;
    do_pop_s     = 1'b0;
    count_next_s = count_r;

    last_nib_s = nib_valid && (nib_cnt_r == LAST_NIB);
    word_s     = {shift_r, nib_in};
    pop_s      = valid_r && instr_ready;

    // A full FIFO still accepts a word when the head leaves on the same edge.
    // Flush overrides both directions and the completing word is discarded.
    if (flush) begin
      push_s   = 1'b0;
      drop_s   = 1'b0;
      do_pop_s = 1'b0;
    end else begin
      push_s   = last_nib_s && ((count_r != FULL_CNT) || pop_s);
      drop_s   = last_nib_s && (count_r == FULL_CNT) && !pop_s;
      do_pop_s = pop_s;
    end

    if (flush) begin
      count_next_s = '0;
    end else begin
      case ({push_s, do_pop_s})
        2'b10:   count_next_s = count_r + ONE_CNT;
        2'b01:   count_next_s = count_r - ONE_CNT;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Nibble assembler: shift in MSB-first, wrap the counter on the last nibble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      shift_r   <= '0;
      nib_cnt_r <= '0;
    end else if (nib_valid) begin
      shift_r <= {shift_r[SH_W-5:0], nib_in};
      if (last_nib_s) begin
        nib_cnt_r <= '0;
      end else begin
        nib_cnt_r <= nib_cnt_r + ONE_NIB;
      end
    end
  end

  // Pointers, occupancy and the registered flags derived from next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      fetch_r  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + ONE_PTR;
        end
        if (do_pop_s) begin
          rd_ptr_r <= rd_ptr_r + ONE_PTR;
        end
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != '0);
      // One slot is kept back for the word already streaming from flash.
      fetch_r <= (count_next_s < HIGH_CNT);
    end
  end

  // Word storage; contents are not reset, readers qualify with instr_valid.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // Sticky overflow/starve flags and the primed marker; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
      starve_r   <= 1'b0;
      primed_r   <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (primed_r && instr_ready && !valid_r) begin
        starve_r <= 1'b1;
      end
      if (push_s) begin
        primed_r <= 1'b1;
      end
    end
  end

  assign instr_out    = mem_r[rd_ptr_r];
  assign instr_valid  = valid_r;
  assign fetch_enable = fetch_r;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign starve       = starve_r;

endmodule

// File: tb/tb_instr_nibble_fifo.sv
module tb_instr_nibble_fifo;

  logic        clk;
  logic        rst;
  logic [3:0]  nib_in;
  logic        nib_valid;
  logic        flush;
  logic [19:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_enable;
  logic [2:0]  count;
  logic        overflow;
  logic        starve;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of words plus an assembler accumulator.
  logic [19:0] q[$];
  logic [19:0] asm_word;
  int          asm_cnt;
  bit          m_over;
  bit          m_starve;
  bit          m_primed;

  instr_nibble_fifo #(.NIBBLES(5), .DEPTH(4), .ADDR_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .nib_in       (nib_in),
    .nib_valid    (nib_valid),
    .flush        (flush),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .fetch_enable (fetch_enable),
    .count        (count),
    .overflow     (overflow),
    .starve       (starve)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic model_update(input logic r, input logic f, input logic nv,
                              input logic [3:0] n, input logic rdy);
    int  pre;
    bit  valid;
    bit  pop;
    pre   = q.size();
    valid = (pre != 0);
    pop   = valid && rdy;
    if (r) begin
      q.delete();
      asm_word = '0; asm_cnt = 0;
      m_over = 0; m_starve = 0; m_primed = 0;
    end else begin
      if (m_primed && rdy && !valid) m_starve = 1;
      if (f) begin
        q.delete();
        asm_word = '0; asm_cnt = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (nv) begin
          asm_word = {asm_word[15:0], n};
          if (asm_cnt == 4) begin
            asm_cnt = 0;
            if (pre < 4 || pop) begin
              q.push_back(asm_word);
              m_primed = 1;
            end else begin
              m_over = 1;
            end
          end else begin
            asm_cnt++;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample #1 later.
  task automatic step(input logic r, input logic f, input logic nv,
                      input logic [3:0] n, input logic rdy);
    rst = r; flush = f; nib_valid = nv; nib_in = n; instr_ready = rdy;
    @(posedge clk);
    model_update(r, f, nv, n, rdy);
    #1;
  endtask

  task automatic send_word(input logic [19:0] w, input logic last_rdy);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, w[(19 - 4*i) -: 4], (i == 4) ? last_rdy : 1'b0);
    end
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    // Partial nibbles before a reset must be discarded.
    step(1'b0, 1'b0, 1'b1, 4'h7, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'h8, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'h9, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", instr_valid); end
    total++; if (fetch_enable !== 1'b1) begin bad++; $display("FAIL reset_fetch got=%0b want=1", fetch_enable); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (overflow !== 1'b0 || starve !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%0b%0b want=00", overflow, starve); end
  endtask

  task automatic test_basic;
    send_word(20'hABCDE, 1'b0);
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", instr_valid); end
    total++; if (instr_out !== 20'hABCDE) begin bad++; $display("FAIL basic_word got=%05h want=ABCDE", instr_out); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", count); end
    total++; if (fetch_enable !== 1'b1) begin bad++; $display("FAIL basic_fetch got=%0b want=1", fetch_enable); end
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    total++; if (instr_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL basic_drain valid=%0b count=%0d want 0/0", instr_valid, count); end
  endtask

  task automatic test_overflow;
    logic [19:0] w[4];
    for (int i = 0; i < 4; i++) w[i] = 20'($urandom);
    send_word(w[0], 1'b0);
    send_word(w[1], 1'b0);
    total++; if (fetch_enable !== 1'b1) begin bad++; $display("FAIL ovf_fetch2 got=%0b want=1", fetch_enable); end
    send_word(w[2], 1'b0);
    total++; if (count !== 3'd3 || fetch_enable !== 1'b0) begin bad++; $display("FAIL ovf_fetch3 count=%0d fetch=%0b want 3/0", count, fetch_enable); end
    send_word(w[3], 1'b0);
    total++; if (count !== 3'd4 || overflow !== 1'b0) begin bad++; $display("FAIL ovf_full count=%0d ovf=%0b want 4/0", count, overflow); end
    send_word(20'h12345, 1'b0);
    total++; if (count !== 3'd4 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_drop count=%0d ovf=%0b want 4/1", count, overflow); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (instr_valid !== 1'b1 || instr_out !== w[i]) begin
        bad++; $display("FAIL ovf_pop%0d got=%05h valid=%0b want=%05h", i, instr_out, instr_valid, w[i]);
      end
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0b want=0", instr_valid); end
  endtask

  task automatic test_full_passthrough;
    logic [19:0] w[5];
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) w[i] = 20'($urandom);
    for (int i = 0; i < 4; i++) send_word(w[i], 1'b0);
    send_word(w[4], 1'b1);
    total++; if (count !== 3'd4 || overflow !== 1'b0) begin bad++; $display("FAIL pass_count count=%0d ovf=%0b want 4/0", count, overflow); end
    for (int i = 1; i < 5; i++) begin
      total++;
      if (instr_valid !== 1'b1 || instr_out !== w[i]) begin
        bad++; $display("FAIL pass_pop%0d got=%05h valid=%0b want=%05h", i, instr_out, instr_valid, w[i]);
      end
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    end
  endtask

  task automatic test_stream;
    logic [19:0] words[25];
    int          sent_n, nib_idx, recv, cyc;
    logic        nv, rdy;
    logic [3:0]  n;
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 25; i++) words[i] = 20'($urandom);
    sent_n = 0; nib_idx = 0; recv = 0; cyc = 0;
    while (recv < 25 && cyc < 3000) begin
      nv = 1'b0; n = 4'h0;
      // A new word only starts when the reader is enabled; a started word always finishes.
      if (sent_n < 25 && (nib_idx != 0 || fetch_enable)) nv = ($urandom_range(0, 3) != 0);
      if (nv) n = words[sent_n][(19 - 4*nib_idx) -: 4];
      rdy = 1'($urandom_range(0, 1));
      if (instr_valid && rdy) begin
        total++;
        if (instr_out !== words[recv]) begin
          bad++; $display("FAIL stream_word%0d got=%05h want=%05h", recv, instr_out, words[recv]);
        end
        recv++;
      end
      step(1'b0, 1'b0, nv, n, rdy);
      if (count !== 3'(q.size())) begin
        total++; bad++; $display("FAIL stream_count cyc=%0d got=%0d want=%0d", cyc, count, q.size());
      end
      if (nv) begin
        nib_idx++;
        if (nib_idx == 5) begin nib_idx = 0; sent_n++; end
      end
      cyc++;
    end
    total++; if (recv != 25) begin bad++; $display("FAIL stream_timeout received=%0d want=25", recv); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stream_ovf got=%0b want=0", overflow); end
    total++; if (starve !== 1'(m_starve)) begin bad++; $display("FAIL stream_starve got=%0b want=%0b", starve, m_starve); end
  endtask

  task automatic test_flush;
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    send_word(20'h0F0F0, 1'b0);
    send_word(20'h55AA3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'h9, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'h8, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'h7, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    total++; if (count !== 3'd0 || instr_valid !== 1'b0) begin bad++; $display("FAIL flush_clear count=%0d valid=%0b want 0/0", count, instr_valid); end
    send_word(20'h12345, 1'b0);
    total++; if (instr_out !== 20'h12345 || count !== 3'd1) begin bad++; $display("FAIL flush_word got=%05h count=%0d want 12345/1", instr_out, count); end
  endtask

  task automatic test_starve_reset;
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) send_word(20'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    total++; if (starve !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL starve_pre starve=%0b valid=%0b want 0/0", starve, instr_valid); end
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    total++; if (starve !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL starve_set starve=%0b ovf=%0b want 1/1", starve, overflow); end
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    total++; if (starve !== 1'b0 || overflow !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL starve_rst starve=%0b ovf=%0b count=%0d want 0/0/0", starve, overflow, count); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; nib_valid = 1'b0; nib_in = 4'h0; instr_ready = 1'b0;
    q.delete(); asm_word = '0; asm_cnt = 0; m_over = 0; m_starve = 0; m_primed = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_passthrough();
    test_stream();
    test_flush();
    test_starve_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_nibble_fifo.md
Name: instr_nibble_fifo

Overview:
- Sits between spi_flash_reader and decode_instr. Replaces the four-stage instruction_buffer shift chain.
- Assembles quad-SPI nibbles into 20-bit instructions and holds them in a small FIFO.
- Presents instructions to the decoder on a valid/ready handshake.
- Drives the SPI reader's read_enable so flash fetch stalls before the FIFO can overflow.

Parameters:
- NIBBLES, 5, nibbles per instruction (20 bits / 4)
- DEPTH, 4, FIFO entries; must be a power of two, >= 2
- ADDR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  pixel/system clock (~25 MHz)
- rst  in  1  synchronous, active-high reset
- nib_in  in  4  nibble from quad-SPI, bit 3 = IO3
- nib_valid  in  1  nib_in valid this cycle (spi data_valid)
- flush  in  1  synchronous clear of assembler and FIFO contents
- instr_out  out  20  head-of-FIFO instruction
- instr_valid  out  1  FIFO non-empty
- instr_ready  in  1  decoder accepts head this cycle
- fetch_enable  out  1  to SPI read_enable; high when room for another instruction
- count  out  ADDR_W+1  occupied entries, 0..DEPTH
- overflow  out  1  sticky: completed word dropped because FIFO was full
- starve  out  1  sticky: decoder requested with FIFO empty after first word

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=rd_ptr=0, count=0, nib_cnt=0, assembler shift register=0, overflow=0, starve=0, primed=0.
- Reset output values: instr_valid=0, fetch_enable=1, instr_out=memory contents at rd_ptr 0 (don't-care; decoder must qualify with instr_valid).
- Reset mid-instruction discards any partial nibbles.
- Assembler:
  - nib_cnt counts 0..NIBBLES-1. Nibbles are MSB-first.
  - On nib_valid with nib_cnt<NIBBLES-1: shift reg <= {shift reg[11:0], nib_in}; nib_cnt++.
  - On nib_valid with nib_cnt==NIBBLES-1: word = {shift reg[15:0], nib_in}; nib_cnt <= 0; push attempted on the same edge.
- Push:
  - Succeeds if count<DEPTH, or if count==DEPTH and a pop occurs on the same edge.
  - Otherwise the word is dropped and overflow <= 1.
  - A successful push writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- Pop:
  - pop = instr_valid & instr_ready. rd_ptr increments modulo DEPTH.
- Output is first-word-fall-through: instr_out = mem[rd_ptr] combinationally, instr_valid = (count!=0).
- Latency:
  - The last nibble accepted at edge N makes the word visible at instr_out/instr_valid after edge N.
  - No same-cycle bypass when empty.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- fetch_enable = (count < DEPTH-1). This guarantees a slot for the instruction already in flight from flash.
- primed sets on the first successful push. starve <= 1 when primed & instr_ready & !instr_valid.
- flush:
  - Clears ptrs, count, nib_cnt and shift reg on the same edge.
  - flush wins over a simultaneous push or pop; the word is not stored.
  - Does not clear overflow, starve or primed. Only rst clears those.
- Pointer wrap: ptrs are ADDR_W bits and wrap naturally. Full/empty is decided by count, not by ptr compare.

Test Plan:
- Reset, then 5 nibbles 0xA,0xB,0xC,0xD,0xE on consecutive cycles with instr_ready=0 -> the cycle after the 5th edge: instr_valid=1, instr_out=20'hABCDE, count=1, fetch_enable=1.
- Push 4 words with instr_ready=0:
  - At count=3, fetch_enable=0.
  - A 5th completed word (e.g. 20'h12345) -> dropped, count stays 4, overflow=1.
  - Popping 4 times returns the first 4 words in order.
- Full FIFO with instr_ready=1 held while a 5th word completes -> pop and push on the same edge, count stays 4, overflow stays 0, order preserved.
- Interleaved streaming, 25 instructions with random nib_valid gaps and random instr_ready -> the decoder sees all words in order across multiple pointer wraps; no overflow.
- Push 2 words, then 3 nibbles of a 3rd, then assert flush -> next cycle count=0, instr_valid=0. The following 5 nibbles 0x1..0x5 yield 20'h12345, confirming the partial word was discarded.
- After one word is pushed and popped, hold instr_ready=1 with no nibbles -> starve=1 on the next edge. Then assert rst=1 for one cycle -> starve=0, overflow=0, count=0.
